// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and line/parity encodings.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Counts 16x-baud strobes and flags the strobe that closes a bit period.
// bit_end is combinational from the strobe; clear holds the count at zero.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bclkx16_en,
  output logic bit_end
);

  localparam int               CNT_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] r_cnt;

  assign bit_end = bclkx16_en && (r_cnt == LAST_TICK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || bit_end) begin
      r_cnt <= '0;
    end else if (bclkx16_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, parity, STOP_BITS stops; all outputs registered.
// Byte accepted on tx_valid && tx_ready; tx_ready stays low for the whole frame, so input is held off.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bclkx16_en,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  parity,
  output logic                  tx_ready,
  output logic                  Tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  import uart_pkg::*;

  localparam int               IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [IDX_W-1:0]      r_bit_idx, w_bit_idx_nxt;
  logic                  r_stop_idx, w_stop_idx_nxt;
  logic                  r_par, w_par_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_timer_clr;
  logic                  w_bit_end;

  // Counter is parked in IDLE so every frame starts from tick zero.
  assign w_timer_clr = (r_state == IDLE);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_timer_clr),
    .bclkx16_en (bclkx16_en),
    .bit_end    (w_bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par      <= 1'b0;
      r_tx       <= IDLE_LEVEL;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_par      <= w_par_nxt;
      r_tx       <= w_tx_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_par_nxt      = r_par;
    case (r_state)
      IDLE: begin
        if (tx_valid) begin
          w_state_nxt    = START;
          w_shift_nxt    = tx_data;
          w_par_nxt      = (^tx_data) ^ parity;
          w_bit_idx_nxt  = '0;
          w_stop_idx_nxt = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == LAST_IDX) begin
            w_state_nxt = PARITY;
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
            w_shift_nxt   = r_shift >> 1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_stop_idx == LAST_STOP) w_state_nxt = IDLE;
          else                         w_stop_idx_nxt = r_stop_idx + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level is decoded from the next state so Tx comes straight off a flop.
  always_comb begin
    w_done_nxt = (r_state == STOP) && (w_state_nxt == IDLE);
    case (w_state_nxt)
      START:   w_tx_nxt = START_LEVEL;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = w_par_nxt;
      default: w_tx_nxt = IDLE_LEVEL;
    endcase
  end

  assign Tx       = r_tx;
  assign tx_done  = r_done;
  assign tx_ready = (r_state == IDLE);
  assign tx_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed frames scored against a queue of hand-computed frames,
// plus a STOP_BITS=2 instance with the strobe tied high.
module tb_uart_tx_frame;

  import uart_pkg::*;

  localparam int OS        = 16;
  localparam int NBITS     = 11;
  localparam int FRAME_STB = NBITS * OS;
  localparam int LIMIT     = 2000;

  typedef struct packed {
    logic [7:0] data;
    logic       par_bit;
    logic       b2b;
  } exp_t;

  logic       clk        = 1'b0;
  logic       rst        = 1'b0;
  logic       bclkx16_en = 1'b0;
  logic       tx_valid   = 1'b0;
  logic [7:0] tx_data    = 8'h00;
  logic       parity     = 1'b0;
  logic       tx_ready, Tx, tx_busy, tx_done;

  logic       tx_valid2  = 1'b0;
  logic [7:0] tx_data2   = 8'h00;
  logic       parity2    = 1'b0;
  logic       tx_ready2, Tx2, tx_busy2, tx_done2;

  int   n_chk     = 0;
  int   n_pass    = 0;
  int   done_seen = 0;
  int   cyc       = 0;
  bit   stb_on    = 1'b1;
  exp_t sb[$];

  uart_tx_frame #(.DATA_WIDTH(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .bclkx16_en(bclkx16_en), .tx_valid(tx_valid),
    .tx_data(tx_data), .parity(parity), .tx_ready(tx_ready), .Tx(Tx),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_frame #(.DATA_WIDTH(8), .OVERSAMPLE(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .bclkx16_en(1'b1), .tx_valid(tx_valid2),
    .tx_data(tx_data2), .parity(parity2), .tx_ready(tx_ready2), .Tx(Tx2),
    .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One strobe every second clock while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bclkx16_en = stb_on ? ~bclkx16_en : 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: samples Tx on every strobe, assembles 176-strobe frames, scores them.
  initial begin : monitor
    bit                   active;
    bit                   want_done;
    bit                   last_b2b;
    int                   idx;
    int                   gap;
    int                   gap_start;
    int                   last_done;
    int                   fno;
    logic                 lvl;
    logic [FRAME_STB-1:0] samp;
    exp_t                 e;
    active = 0; want_done = 0; last_b2b = 0;
    idx = 0; gap = 0; gap_start = 0; last_done = 0; fno = 0;
    samp = '0;
    e = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active    = 0;
        idx       = 0;
        want_done = 0;
      end else begin
        if (tx_done) done_seen++;
        if (want_done) begin
          want_done = 0;
          chk($sformatf("frame%0d_done_ready_busy", fno), 32'({tx_done, tx_ready, tx_busy}), 32'b110);
          if (last_b2b) chk($sformatf("frame%0d_done_spacing", fno), 32'(cyc - last_done), 32'(2 * FRAME_STB));
          last_done = cyc;
        end
        if (bclkx16_en) begin
          if (!active && Tx == START_LEVEL) begin
            active    = 1;
            idx       = 0;
            gap_start = gap;
            gap       = 0;
          end
          if (active) begin
            samp[idx] = Tx;
            idx++;
            if (idx == FRAME_STB) begin
              active    = 0;
              want_done = 1;
              fno++;
              chk($sformatf("frame%0d_expected", fno), 32'(sb.size() != 0), 32'd1);
              last_b2b = 0;
              if (sb.size() != 0) begin
                e        = sb.pop_front();
                last_b2b = e.b2b;
                for (int b = 0; b < NBITS; b++) begin
                  if (b == 0)      lvl = START_LEVEL;
                  else if (b <= 8) lvl = e.data[b-1];
                  else if (b == 9) lvl = e.par_bit;
                  else             lvl = IDLE_LEVEL;
                  chk($sformatf("frame%0d_bit%0d", fno, b), 32'(samp[b*OS +: OS]), 32'({OS{lvl}}));
                end
                if (e.b2b) chk($sformatf("frame%0d_zero_gap", fno), 32'(gap_start), 32'd0);
              end
            end
          end else if (Tx == IDLE_LEVEL) begin
            gap++;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic p, input logic hold);
    int t;
    t        = 0;
    tx_data  = d;
    parity   = p;
    tx_valid = 1'b1;
    while (t < LIMIT) begin
      @(negedge clk);
      if (tx_ready) break;
      t++;
    end
    chk("handshake_in_time", 32'(t < LIMIT), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input logic p, input logic exp_par,
                       input logic b2b, input logic hold);
    exp_t e;
    e.data    = d;
    e.par_bit = exp_par;
    e.b2b     = b2b;
    sb.push_back(e);
    send(d, p, hold);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (t < LIMIT) begin
      @(negedge clk);
      if (tx_ready) break;
      t++;
    end
    chk("idle_in_time", 32'(t < LIMIT), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int n;
    int zeros;
    int highs;
    bit got_done;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_Tx",       32'(Tx),       32'd1);
    chk("reset_tx_ready", 32'(tx_ready), 32'd1);
    chk("reset_tx_busy",  32'(tx_busy),  32'd0);
    chk("reset_tx_done",  32'(tx_done),  32'd0);
    chk("reset_Tx2",      32'(Tx2),      32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 0xCF has six ones: even -> 0, odd -> 1.
    frame(8'hCF, PARITY_EVEN, 1'b0, 1'b0, 1'b0);
    wait_idle();
    frame(8'hCF, PARITY_ODD, 1'b1, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back with tx_valid held across both handshakes.
    frame(8'h00, PARITY_EVEN, 1'b0, 1'b0, 1'b1);
    frame(8'hFF, PARITY_ODD,  1'b1, 1'b1, 1'b0);
    wait_idle();

    // 0x3C odd -> 1; a 0x55 pulse mid-frame must be dropped.
    frame(8'h3C, PARITY_ODD, 1'b1, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("ready_low_midframe", 32'(tx_ready), 32'd0);
    tx_data  = 8'h55;
    parity   = PARITY_EVEN;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    wait_idle();
    repeat (400) @(posedge clk);
    #1;
    chk("idle_after_ignored_Tx",   32'(Tx),      32'd1);
    chk("idle_after_ignored_busy", 32'(tx_busy), 32'd0);

    // 0xA5 abandoned by reset during data bit 3 (a 0 bit).
    send(8'hA5, PARITY_EVEN, 1'b0);
    repeat (140) @(posedge clk);
    @(negedge clk);
    chk("bit3_level_before_reset", 32'(Tx),      32'd0);
    chk("busy_before_reset",       32'(tx_busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("reset_midframe_Tx",    32'(Tx),       32'd1);
    chk("reset_midframe_ready", 32'(tx_ready), 32'd1);
    chk("reset_midframe_busy",  32'(tx_busy),  32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    frame(8'h81, PARITY_EVEN, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // 0x07 odd -> 0; strobes paused for 100 clocks inside data bit 0 (a 1 bit).
    frame(8'h07, PARITY_ODD, 1'b0, 1'b0, 1'b0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    stb_on = 1'b0;
    repeat (100) @(negedge clk);
    chk("hold_without_strobe_Tx",   32'(Tx),      32'd1);
    chk("hold_without_strobe_busy", 32'(tx_busy), 32'd1);
    stb_on = 1'b1;
    wait_idle();

    // STOP_BITS=2 with the strobe tied high: 160 low clocks, 32 high, done on clock 193.
    tx_data2  = 8'h00;
    parity2   = PARITY_EVEN;
    tx_valid2 = 1'b1;
    @(posedge clk);
    #1 tx_valid2 = 1'b0;
    n = 0; zeros = 0; highs = 0; got_done = 0;
    while (n < 400 && !got_done) begin
      @(negedge clk);
      n++;
      if (tx_done2)     got_done = 1;
      else if (Tx2 == 0) begin zeros++; highs = 0; end
      else              highs++;
    end
    chk("stop2_done_cycle",  32'(n),        32'd193);
    chk("stop2_low_cycles",  32'(zeros),    32'd160);
    chk("stop2_high_tail",   32'(highs),    32'd32);
    chk("stop2_ready_after", 32'(tx_ready2), 32'd1);
    chk("stop2_busy_after",  32'(tx_busy2),  32'd0);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("tx_done_count",      32'(done_seen), 32'd7);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
